seq_detector_prog: RTL
======================

# seq_detector_prog

Runtime-programmable serial sequence detector. It is the parametrised successor to the fixed-pattern detectors in the sequence_detector library. The block compares a serial bit stream against a loadable pattern of 1..MAX_LEN bits and can run in overlapping or non-overlapping mode. For each match it emits a one-cycle pulse and keeps a saturating match count. It sits behind the serial input pins and drives the event/interrupt logic.

## Interface
Parameters:
- MAX_LEN, 8: maximum pattern length in bits; legal range 2..32.
- CNT_W, 8: width of the match counter.
- LEN_W, $clog2(MAX_LEN+1): width of cfg_len. Derived; not to be overridden.

Ports:
- CLK  input  1  clock; all logic on the rising edge.
- RST  input  1  synchronous, active-high reset.
- S_input  input  1  serial data bit; sampled only when in_valid=1.
- in_valid  input  1  S_input qualifier; gaps are allowed.
- cfg_we  input  1  one-cycle configuration write strobe.
- cfg_pattern  input  MAX_LEN  pattern; bit [cfg_len-1] is the first bit received, bit [0] the last.
- cfg_len  input  LEN_W  pattern length; legal values are 1..MAX_LEN.
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- cnt_clr  input  1  synchronous clear of match_count.
- D_output  output  1  match pulse.
- match_count  output  CNT_W  saturating count of matches.
- cfg_err  output  1  one-cycle pulse when a cfg_we write is rejected.
- armed  output  1  high while a valid configuration is loaded.

## Operation
- FSM with two states, UNCFG and ARMED.
  - Reset always enters UNCFG.
  - A legal cfg_we moves the FSM to ARMED. It stays in ARMED until the next reset.
  - In UNCFG, input bits are ignored and D_output stays 0.
- Configuration write:
  - A write is legal when 1 ≤ cfg_len ≤ MAX_LEN.
  - A legal write latches pattern, len and overlap. It clears hist and fill. match_count is left unchanged.
  - An illegal write (cfg_len = 0 or cfg_len > MAX_LEN) is discarded. The previous configuration and state are kept, and cfg_err pulses.
- Internal state:
  - hist is a MAX_LEN-bit shift register. On an accepted bit: hist ← {hist[MAX_LEN-2:0], S_input}.
  - fill counts accepted bits since the last clear and saturates at MAX_LEN.
- Match condition, evaluated on each accepted bit in ARMED using the post-shift values:
  - fill_next ≥ len, and
  - hist_next[len-1:0] == pattern[len-1:0].
- On a match:
  - D_output pulses.
  - match_count increments, saturating at 2^CNT_W−1.
  - If overlap=0, fill is cleared to 0, so the bits of the matched occurrence cannot be reused.
  - If overlap=1, fill is not cleared.
- Simultaneous events:
  - cfg_we with in_valid: the configuration write wins and the bit is discarded. This holds even when the write is illegal.
  - cnt_clr with a match: match_count becomes 0 (clear wins), and D_output still pulses.
- No combinational path from any input to any output.

## Timing
- Reset values, on the first rising edge with RST=1: D_output=0, match_count=0, cfg_err=0, armed=0, hist=0, fill=0, state=UNCFG. Pattern, len and overlap registers are cleared to 0.
- Reset mid-stream discards all history. Detection resumes only after a new legal cfg_we.
- D_output latency: high for exactly the one cycle after the edge that samples the completing bit.
- match_count updates on the same edge that raises D_output.
- cfg_err asserts in the cycle after the rejected cfg_we, for one cycle.
- armed rises in the cycle after a legal cfg_we.
- A bit presented the cycle after cfg_we is accepted as the first pattern bit.
- in_valid=0 cycles freeze hist and fill.
- D_output pulses on consecutive cycles when matches occur on back-to-back bits.
- Throughput: one bit per clock.

## Test plan
- Pattern 1110, len=4, overlap=0. Stream 0,1,1,1,0 with no gaps. Required: D_output is high only in the cycle after the 5th bit, match_count=1.
- Pattern 11, len=2, overlap=1. Stream 1,1,1,1. Required: D_output high after bits 2, 3 and 4, match_count=3. Repeat with overlap=0: pulses after bits 2 and 4 only, match_count=2.
- in_valid gaps: the 1110 stream with 3 idle cycles between each bit. Required: the same single match one cycle after the last accepted bit.
- cfg_we with cfg_len=0, then with cfg_len=MAX_LEN+1, while armed. Required: cfg_err pulses each time, and the old pattern still detects.
- Saturation with CNT_W=2 and pattern 1, len=1. Stream of 6 ones. Required: match_count goes 1,2,3,3,3,3. Then assert cnt_clr together with a matching bit: match_count=0 and D_output=1 in that cycle.
- Assert RST after 1,1,1, then reconfigure and send 0. Required: no match, and armed=0 until the reconfiguration.

Source files
------------

// File: rtl/seq_detector_prog_if.sv
// seq_detector_prog_if
// Bundles the serial data stream, configuration bus and status outputs of
// seq_detector_prog. Clock and reset stay outside the interface.
//   S_input/in_valid       : qualified serial bit stream
//   cfg_we/cfg_pattern/
//   cfg_len/cfg_overlap    : configuration write
//   cnt_clr                : synchronous clear of the match counter
//   D_output/match_count/
//   cfg_err/armed          : detector status, all registered
// master = stimulus side, slave = detector side.
interface seq_detector_prog_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
    logic                S_input;
    logic                in_valid;
    logic                cfg_we;
    logic [MAX_LEN-1:0]  cfg_pattern;
    logic [LEN_W-1:0]    cfg_len;
    logic                cfg_overlap;
    logic                cnt_clr;
    logic                D_output;
    logic [CNT_W-1:0]    match_count;
    logic                cfg_err;
    logic                armed;

    modport master (
        output S_input, in_valid, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
        input  D_output, match_count, cfg_err, armed
    );

    modport slave (
        input  S_input, in_valid, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
        output D_output, match_count, cfg_err, armed
    );
endinterface

// File: rtl/seq_detector_prog.sv
// seq_detector_prog
// Runtime-programmable serial sequence detector. Compares the qualified bit
// stream against a loaded pattern of 1..MAX_LEN bits, in overlapping or
// non-overlapping mode, pulsing D_output for one cycle per match and keeping
// a saturating match count.
// Ports:
//   CLK  : clock, rising edge
//   RST  : synchronous active-high reset
//   bus  : seq_detector_prog_if.slave (stream, config, status)
module seq_detector_prog #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               CLK,
    input  logic               RST,
    seq_detector_prog_if.slave bus
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    typedef enum logic {UNCFG = 1'b0, ARMED = 1'b1} state_t;

    state_t              state_q;
    logic [MAX_LEN-1:0]  pattern_q;
    logic [LEN_W-1:0]    len_q;
    logic                overlap_q;
    logic [MAX_LEN-1:0]  hist_q, hist_d;
    logic [LEN_W-1:0]    fill_q, fill_d, fill_inc;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                d_q;
    logic                err_q;

    logic [MAX_LEN-1:0]  len_mask;
    logic                cfg_legal;
    logic                bit_acc;
    logic                match;

    always_comb begin
        cfg_legal = (bus.cfg_len != '0) && (bus.cfg_len <= MAX_LEN_L);
        // A configuration write in the same cycle swallows the data bit.
        bit_acc   = (state_q == ARMED) && bus.in_valid && !bus.cfg_we;
        hist_d    = {hist_q[MAX_LEN-2:0], bus.S_input};
        fill_inc  = (fill_q >= MAX_LEN_L) ? MAX_LEN_L : fill_q + 1'b1;

        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LEN_W'(i) < len_q);
        end

        // Match is judged on the post-shift history and fill.
        match  = bit_acc && (fill_inc >= len_q) &&
                 (((hist_d ^ pattern_q) & len_mask) == '0);
        // Non-overlapping mode forgets the bits of the occurrence just matched.
        fill_d = (match && !overlap_q) ? '0 : fill_inc;

        cnt_d = cnt_q;
        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= UNCFG;
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            hist_q    <= '0;
            fill_q    <= '0;
            cnt_q     <= '0;
            d_q       <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            d_q   <= match;
            err_q <= 1'b0;
            cnt_q <= cnt_d;
            if (bus.cfg_we) begin
                if (cfg_legal) begin
                    state_q   <= ARMED;
                    pattern_q <= bus.cfg_pattern;
                    len_q     <= bus.cfg_len;
                    overlap_q <= bus.cfg_overlap;
                    hist_q    <= '0;
                    fill_q    <= '0;
                end else begin
                    err_q <= 1'b1;
                end
            end else if (bit_acc) begin
                hist_q <= hist_d;
                fill_q <= fill_d;
            end
        end
    end

    assign bus.D_output    = d_q;
    assign bus.match_count = cnt_q;
    assign bus.cfg_err     = err_q;
    assign bus.armed       = (state_q == ARMED);

endmodule
